// File: rtl/img_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : img_loader
// Description : Write end of the 160x120 8-bit grayscale frame memory.
//               Turns a raster-ordered valid/ready pixel stream into a
//               registered write port (x, y, linear address, data).
//               Optional fill engine enabled by IMG_LOADER_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module img_loader #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     s_valid,
  input  logic [7:0]                               s_data,
  input  logic                                     s_sof,
  output logic                                     s_ready,
  input  logic                                     clear_start,
  input  logic [7:0]                               fill_value,
  output logic                                     wr_en,
  output logic [$clog2(IMG_WIDTH)-1:0]             wr_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]            wr_y,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]  wr_addr,
  output logic [7:0]                               wr_data,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic                                     clear_done,
  output logic                                     sync_err
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int AW = $clog2(IMG_WIDTH*IMG_HEIGHT);

  localparam logic [XW-1:0] C_X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [AW-1:0] C_A_LAST   = AW'(IMG_WIDTH*IMG_HEIGHT - 1);
  localparam logic [AW-1:0] C_A_PENULT = AW'(IMG_WIDTH*IMG_HEIGHT - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            wr_en_q, wr_en_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            frame_done_q, frame_done_d;
  logic            clear_done_q, clear_done_d;
  logic            sync_err_q, sync_err_d;

  logic            w_accept;
  logic            w_x_wrap;
  logic [XW-1:0]   w_x_next;
  logic [YW-1:0]   w_y_next;
  logic [AW-1:0]   w_addr_next;
  logic            w_next_is_last;

  // Ready depends only on state: the stream is stalled while filling.
  assign s_ready  = (state_q != ST_CLEAR);
  assign busy     = (state_q != ST_IDLE);
  assign w_accept = s_valid & s_ready;

  // Next raster position after the last written one; address stays in step
  // with x/y by incrementing, so no multiplier is needed.
  assign w_x_wrap       = (x_q == C_X_LAST);
  assign w_x_next       = w_x_wrap ? '0 : x_q + XW'(1);
  assign w_y_next       = w_x_wrap ? y_q + YW'(1) : y_q;
  assign w_addr_next    = addr_q + AW'(1);
  assign w_next_is_last = (addr_q == C_A_PENULT);

`ifdef IMG_LOADER_CLEAR_EN
  logic [7:0] fill_q, fill_d;
`else
  logic w_unused_clear;
  assign w_unused_clear = clear_start ^ (^fill_value);
`endif

  // Next-state and next-write computation; all outputs registered.
  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    clear_done_d = 1'b0;
    sync_err_d   = 1'b0;
`ifdef IMG_LOADER_CLEAR_EN
    fill_d       = fill_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_accept && s_sof) begin
          wr_en_d = 1'b1;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          data_d  = s_data;
          state_d = ST_LOAD;
        end
`ifdef IMG_LOADER_CLEAR_EN
        else if (clear_start) begin
          fill_d  = fill_value;
          wr_en_d = 1'b1;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          data_d  = fill_value;
          state_d = ST_CLEAR;
        end
`endif
      end
      ST_LOAD: begin
        if (w_accept) begin
          wr_en_d = 1'b1;
          data_d  = s_data;
          if (s_sof) begin
            // Resync: restart the raster at the origin.
            x_d        = '0;
            y_d        = '0;
            addr_d     = '0;
            sync_err_d = 1'b1;
          end else begin
            x_d    = w_x_next;
            y_d    = w_y_next;
            addr_d = w_addr_next;
            if (w_next_is_last) begin
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end
          end
        end
      end
      ST_CLEAR: begin
`ifdef IMG_LOADER_CLEAR_EN
        // Stay here through the final fill write, leave on the cycle after.
        if (addr_q == C_A_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wr_en_d = 1'b1;
          x_d     = w_x_next;
          y_d     = w_y_next;
          addr_d  = w_addr_next;
          data_d  = fill_q;
          if (w_next_is_last) clear_done_d = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      clear_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      clear_done_q <= clear_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

`ifdef IMG_LOADER_CLEAR_EN
  // Fill value latched when a clear is accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) fill_q <= '0;
    else          fill_q <= fill_d;
  end
  assign clear_done = clear_done_q;
`else
  assign clear_done = 1'b0;
  logic w_unused_cd;
  assign w_unused_cd = clear_done_q;
`endif

  assign wr_en      = wr_en_q;
  assign wr_x       = x_q;
  assign wr_y       = y_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_img_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_img_loader
// Description : Self-checking bench for img_loader with a position-index
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_loader;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int TOTAL = W * H;
`ifdef IMG_LOADER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid, s_sof, clear_start;
  logic [7:0]  s_data, fill_value;
  logic        s_ready, wr_en, busy, frame_done, clear_done, sync_err;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;

  img_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof), .s_ready(s_ready),
    .clear_start(clear_start), .fill_value(fill_value),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .clear_done(clear_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 streaming, 2 filling; position is a
  // plain linear index, x/y derived by division.
  int   m_mode = 0;
  int   m_pos  = 0;
  logic [7:0] m_fill = 8'h00;
  logic [7:0] e_data = 8'h00;
  bit   e_en = 0, e_fd = 0, e_cd = 0, e_se = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_mode = 0; m_pos = 0; e_data = 8'h00;
      e_en = 0; e_fd = 0; e_cd = 0; e_se = 0;
    end else begin
      bit acc;
      e_en = 0; e_fd = 0; e_cd = 0; e_se = 0;
      acc = s_valid && (m_mode != 2);
      case (m_mode)
        0: begin
          if (acc && s_sof) begin
            m_pos = 0; e_data = s_data; e_en = 1; m_mode = 1;
          end else if (CLEAR_EN && clear_start) begin
            m_fill = fill_value; m_pos = 0; e_data = fill_value; e_en = 1; m_mode = 2;
          end
        end
        1: begin
          if (acc) begin
            e_en = 1; e_data = s_data;
            if (s_sof) begin
              m_pos = 0; e_se = 1;
            end else begin
              m_pos = m_pos + 1;
              if (m_pos == TOTAL - 1) begin e_fd = 1; m_mode = 0; end
            end
          end
        end
        default: begin
          if (m_pos == TOTAL - 1) m_mode = 0;
          else begin
            m_pos = m_pos + 1; e_en = 1; e_data = m_fill;
            if (m_pos == TOTAL - 1) e_cd = 1;
          end
        end
      endcase
    end
  end

  // Statistics gathered alongside the per-cycle compare.
  int n_writes = 0, n_fd = 0, n_cd = 0, n_se = 0, n_nr = 0, n_7f = 0;
  int fd_addr = -1, cd_addr = -1, prev_addr = -1, after159 = -1;

  // Per-cycle compare of every output against the model.
  always @(posedge clk) begin
    bit bad;
    #1;
    bad = (wr_en !== e_en) || (frame_done !== e_fd) || (clear_done !== e_cd) ||
          (sync_err !== e_se) || (busy !== (m_mode != 0)) || (s_ready !== (m_mode != 2));
    if (e_en)
      bad = bad || (wr_addr !== m_pos) || (wr_x !== (m_pos % W)) ||
            (wr_y !== (m_pos / W)) || (wr_data !== e_data);
    n_tests++;
    if (bad) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL cycle_cmp t=%0t en=%b/%b addr=%0d/%0d x=%0d/%0d y=%0d/%0d data=%02h/%02h fd=%b/%b cd=%b/%b se=%b/%b busy=%b ready=%b mode=%0d",
                 $time, wr_en, e_en, wr_addr, m_pos, wr_x, m_pos % W, wr_y, m_pos / W,
                 wr_data, e_data, frame_done, e_fd, clear_done, e_cd, sync_err, e_se,
                 busy, s_ready, m_mode);
    end
    if (wr_en === 1'b1) begin
      n_writes++;
      if (wr_data == 8'h7F) n_7f++;
      if (prev_addr == 159 && after159 < 0) after159 = int'(wr_addr);
      prev_addr = int'(wr_addr);
    end
    if (frame_done === 1'b1) begin n_fd++; fd_addr = int'(wr_addr); end
    if (clear_done === 1'b1) begin n_cd++; cd_addr = int'(wr_addr); end
    if (sync_err === 1'b1) n_se++;
    if (s_ready === 1'b0) n_nr++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic beat(input bit sof, input logic [7:0] d);
    @(negedge clk);
    s_valid = 1'b1; s_sof = sof; s_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0; s_sof = 1'b0; clear_start = 1'b0;
    end
  endtask

  task automatic sample();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; clear_start = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int w0, f0, c0, nr0, s0, k0;
    logic [7:0] d8;
    reset_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 8'h00;
    clear_start = 1'b0; fill_value = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    sample();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_addr", wr_addr, 0);
    @(negedge clk); reset_n = 1'b1;

    // Full frame, data = addr[7:0]
    w0 = n_writes; f0 = n_fd;
    for (int i = 0; i < TOTAL; i++) begin
      d8 = i[7:0];
      beat(i == 0, d8);
    end
    sample();
    chk("frame_done_last", frame_done, 1);
    chk("last_x", wr_x, 159);
    chk("last_y", wr_y, 119);
    chk("last_addr", wr_addr, 19199);
    chk("last_data", wr_data, 8'hFF);
    idle(1);
    sample();
    chk("busy_after_frame", busy, 0);
    chk("frame_writes", n_writes - w0, 19200);
    chk("frame_done_count", n_fd - f0, 1);

    // Non-sof beats in idle are dropped
    w0 = n_writes;
    for (int i = 0; i < 5; i++) beat(1'b0, 8'hAA);
    sample();
    chk("idle_drop_writes", n_writes - w0, 0);
    beat(1'b1, 8'h11);
    sample();
    chk("sof_first_en", wr_en, 1);
    chk("sof_first_addr", wr_addr, 0);
    chk("sof_first_data", wr_data, 8'h11);

    // Mid-frame resync after 300 beats
    for (int i = 1; i < 300; i++) begin d8 = i[7:0]; beat(1'b0, d8); end
    s0 = n_se;
    beat(1'b1, 8'h5C);
    sample();
    chk("resync_err", sync_err, 1);
    chk("resync_addr", wr_addr, 0);
    chk("resync_data", wr_data, 8'h5C);
    beat(1'b0, 8'h01);
    sample();
    chk("resync_next_x", wr_x, 1);
    chk("resync_next_y", wr_y, 0);
    f0 = n_fd;
    for (int i = 2; i < TOTAL - 1; i++) begin d8 = i[7:0]; beat(1'b0, d8); end
    sample();
    chk("resync_no_early_done", n_fd - f0, 0);
    beat(1'b0, 8'hEE);
    sample();
    chk("resync_frame_done", frame_done, 1);
    chk("resync_done_addr", wr_addr, 19199);
    chk("sync_err_count", n_se - s0, 1);
    idle(2);

    // Valid toggling across the row boundary
    w0 = n_writes; after159 = -1;
    beat(1'b1, 8'h00);
    for (int i = 1; i <= 170; i++) begin
      d8 = i[7:0];
      beat(1'b0, d8);
      idle(1);
    end
    idle(1);
    chk("toggle_writes", n_writes - w0, 171);
    chk("toggle_after159", after159, 160);
    do_reset();

`ifdef IMG_LOADER_CLEAR_EN
    // Fill the frame with 0x7F
    w0 = n_writes; c0 = n_cd; nr0 = n_nr; k0 = n_7f;
    @(negedge clk); clear_start = 1'b1; fill_value = 8'h7F;
    @(negedge clk); clear_start = 1'b0; fill_value = 8'h00;
    for (int k = 0; k < TOTAL + 50 && n_cd == c0; k++) @(posedge clk);
    #2;
    chk("clear_done_count", n_cd - c0, 1);
    chk("clear_done_addr", cd_addr, 19199);
    idle(3);
    chk("clear_not_ready_cycles", n_nr - nr0, 19200);
    chk("clear_writes", n_writes - w0, 19200);
    chk("clear_7f_writes", n_7f - k0, 19200);
    chk("clear_back_idle", busy, 0);

    // clear_start together with a sof beat: stream wins
    @(negedge clk); clear_start = 1'b1; fill_value = 8'h33;
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h44;
    @(negedge clk); clear_start = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
    chk("sof_wins_ready", s_ready, 1);
    chk("sof_wins_busy", busy, 1);
    chk("sof_wins_data", wr_data, 8'h44);
    do_reset();
`else
    // Without the fill engine clear_start does nothing
    w0 = n_writes; c0 = n_cd;
    @(negedge clk); clear_start = 1'b1; fill_value = 8'h7F;
    idle(4);
    chk("noclear_writes", n_writes - w0, 0);
    chk("noclear_busy", busy, 0);
    chk("noclear_done", n_cd - c0, 0);
`endif

    // Reset at write 5000 of a load
    beat(1'b1, 8'h00);
    for (int i = 1; i < 5000; i++) begin d8 = i[7:0]; beat(1'b0, d8); end
    sample();
    chk("pre_reset_addr", wr_addr, 4999);
    f0 = n_fd;
    @(negedge clk); reset_n = 1'b0;
    sample();
    chk("abort_wr_en", wr_en, 0);
    chk("abort_addr", wr_addr, 0);
    chk("abort_x", wr_x, 0);
    chk("abort_y", wr_y, 0);
    chk("abort_data", wr_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", s_ready, 1);
    chk("abort_frame_done", frame_done, 0);
    @(negedge clk); reset_n = 1'b1; s_valid = 1'b0;
    w0 = n_writes;
    idle(3);
    chk("abort_no_writes", n_writes - w0, 0);
    chk("abort_no_done", n_fd - f0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/img_loader.md
# img_loader

Frame writer for the 160x120 8-bit grayscale image memory. The zoom path and the VGA side only ever read that memory. This block is the write end. It accepts a raster-ordered pixel stream over a valid/ready handshake and converts it into a registered write port, carrying both (x, y) coordinates and a linear address. An optional fill engine clears the frame to a constant value.

## Interface
Parameters:
- IMG_WIDTH, 160, pixels per line
- IMG_HEIGHT, 120, lines per frame

Ports:
- clk  in  1  core clock; single clock domain
- reset_n  in  1  synchronous, active-low reset
- s_valid  in  1  stream beat valid
- s_data  in  8  pixel value
- s_sof  in  1  beat is pixel (0,0) of a new frame
- s_ready  out  1  block accepts a beat this cycle
- clear_start  in  1  single-cycle request to fill the frame (macro-dependent)
- fill_value  in  8  fill pixel, sampled on the cycle clear_start is accepted
- wr_en  out  1  memory write strobe
- wr_x  out  $clog2(IMG_WIDTH)  write column
- wr_y  out  $clog2(IMG_HEIGHT)  write row
- wr_addr  out  $clog2(IMG_WIDTH*IMG_HEIGHT)  linear address, wr_y*IMG_WIDTH+wr_x
- wr_data  out  8  write pixel
- busy  out  1  state is LOAD or CLEAR
- frame_done  out  1  one-cycle pulse when the last stream pixel is written
- clear_done  out  1  one-cycle pulse when the last fill pixel is written
- sync_err  out  1  one-cycle pulse when s_sof arrives mid-frame

## Operation
- A beat is accepted when s_valid & s_ready.
- States:
  - IDLE: s_ready=1.
    - An accepted beat with s_sof=0 is discarded; no write is issued.
    - An accepted beat with s_sof=1 writes (0,0) and moves to LOAD.
    - clear_start with no accepted beat moves to CLEAR.
  - LOAD: s_ready=1. Each accepted beat writes the next raster position, advancing x and then y.
    - An accepted beat with s_sof=1 pulses sync_err, writes its pixel at (0,0) and restarts the raster. The state stays LOAD.
    - The beat at (IMG_WIDTH-1, IMG_HEIGHT-1) ends the frame and returns to IDLE.
    - clear_start is ignored.
  - CLEAR: s_ready=0. One write per cycle of the latched fill_value over all IMG_WIDTH*IMG_HEIGHT positions in raster order, then IDLE.
- Simultaneous events in IDLE:
  - If clear_start arrives with an accepted s_sof beat, the stream wins and clear_start is dropped.
  - If clear_start arrives with a discarded non-sof beat, clear wins.
- Address arithmetic:
  - wr_addr is kept as an incremental counter; no multiplier.
  - It resets to 0 at the frame start and on a resync.
  - x wraps from IMG_WIDTH-1 to 0 and y increments at the same time.
  - Neither x nor y ever exceeds its bound.
- s_data is not interpreted; the value is written unchanged.

## Timing
- Write latency is 1 cycle. A beat accepted at edge N produces wr_en=1 with its x, y, addr and data registered in the cycle after edge N.
- wr_en is high for exactly one cycle per accepted LOAD/sof beat. With back-to-back beats it stays high continuously.
- frame_done and clear_done are asserted in the same cycle as the final write.
- sync_err is asserted in the same cycle as the (0,0) write of the resync beat.
- CLEAR: clear_start accepted at edge N gives the first fill write in the cycle after N. Fill writes run for IMG_WIDTH*IMG_HEIGHT consecutive cycles (19200 by default), and the block is back in IDLE after the last one.
- s_ready is a function of state only and never depends on s_valid.
- Reset:
  - reset_n low at an edge forces IDLE.
  - All outputs and counters go to 0; s_ready goes to 1 after that edge.
  - Reset mid-LOAD or mid-CLEAR aborts the operation silently: no done pulse, no further writes.

## Configuration
- IMG_LOADER_CLEAR_EN defined:
  - The CLEAR state, the fill_value latch and clear_done are implemented as described above.
- IMG_LOADER_CLEAR_EN undefined:
  - clear_start and fill_value are ignored and CLEAR is unreachable.
  - clear_done is tied to 0.
  - The stream behaviour is unchanged.

## Test plan
- Reset, then a full frame of 19200 back-to-back beats with s_sof on the first and data=addr[7:0].
  - Required: 19200 writes, wr_addr 0..19199 monotonic, wr_x/wr_y match addr.
  - Required: frame_done on the write to (159,119), busy=0 the next cycle.
- Beats with s_sof=0 in IDLE (data 0xAA x5), then a sof beat with 0x11.
  - Required: no writes for the first five beats; the first write is (0,0)=0x11.
- Mid-frame resync: sof frame, 300 beats, then a sof beat with 0x5C.
  - Required: sync_err pulse; write (0,0)=0x5C.
  - Required: the next beat writes (1,0), and frame_done fires only after 19199 more beats.
- s_valid toggling 1/0 every cycle through row 0, crossing x=159.
  - Required: exactly one write per accepted beat.
  - Required: after (159,0) comes (0,1), addr 160.
- With IMG_LOADER_CLEAR_EN: clear_start with fill_value=0x7F in IDLE.
  - Required: s_ready=0 for 19200 cycles, every write carries data 0x7F.
  - Required: clear_done on addr 19199.
  - Also: clear_start in the same cycle as an accepted sof beat gives LOAD, with no clear.
- Reset asserted at write 5000 of a load.
  - Required: the next cycle has wr_en=0, all outputs 0, IDLE, no done pulse.
